// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions.
// Provides the block-width constants, the FSM state type, the S-box and
// xtime helpers, and the Rcon table used by the key-expansion step.
package aes_pkg;

   localparam int BLOCK_W     = 128;
   localparam int BLOCK_BYTES = BLOCK_W / 8;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   // Byte 0x00 sits in the top byte, so entry x lives at bits [(255-x)*8 +: 8].
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Indexed directly by the 4-bit round counter; only entries 1..10 are used.
   localparam logic [7:0] RCON_TBL [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      return RCON_TBL[r];
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one combinational AES-128 key-expansion round.
// Ports: key_in  - current round key (word 0 in bits [127:96])
//        rcon    - round constant applied to the first word
//        key_out - next round key
module aes_key_step
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] key_in,
   input  logic [7:0]         rcon,
   output logic [BLOCK_W-1:0] key_out
);

   logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key_in;
   assign rot  = {w3[23:0], w3[31:24]};
   assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
   assign n0   = w0 ^ temp;
   assign n1   = w1 ^ n0;
   assign n2   = w2 ^ n1;
   assign n3   = w3 ^ n2;
   assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryptor, one round per clock.
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready/plaintext/key   - job input handshake
//        out_valid/out_ready/ciphertext    - result output handshake
//        busy                              - a job is in ROUND or DONE
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BLOCK_W-1:0]   plaintext,
   input  logic [32*Nk-1:0]     key,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BLOCK_W-1:0]   ciphertext,
   output logic                 busy
);

   state_t             fsm;
   logic [BLOCK_W-1:0] state_reg, rk_reg, next_key, round_out;
   logic [3:0]         round_cnt;
   logic               last;
   logic [7:0]         sb [BLOCK_BYTES];
   logic [7:0]         sr [BLOCK_BYTES];
   logic [7:0]         mc [BLOCK_BYTES];

   assign in_ready = (fsm == IDLE);
   assign busy     = (fsm != IDLE);
   assign last     = (round_cnt == 4'(Nr));

   aes_key_step u_key_step (
      .key_in  (rk_reg),
      .rcon    (rcon(round_cnt)),
      .key_out (next_key)
   );

   // Byte i of the block is row i%4, column i/4 and lives at bits [127-8i -: 8].
   genvar i, c, r;
   for (i = 0; i < BLOCK_BYTES; i++) begin : g_sub
      assign sb[i] = sbox(state_reg[BLOCK_W-1-8*i -: 8]);
   end

   for (c = 0; c < 4; c++) begin : g_col
      for (r = 0; r < 4; r++) begin : g_row
         // Row r rotates left by r columns.
         assign sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
      assign mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
   end

   // The final round omits MixColumns.
   for (i = 0; i < BLOCK_BYTES; i++) begin : g_ark
      assign round_out[BLOCK_W-1-8*i -: 8] = (last ? sr[i] : mc[i]) ^ next_key[BLOCK_W-1-8*i -: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm        <= IDLE;
         out_valid  <= 1'b0;
         ciphertext <= '0;
         state_reg  <= '0;
         rk_reg     <= '0;
         round_cnt  <= '0;
      end else begin
         case (fsm)
            IDLE: if (in_valid) begin
               state_reg <= plaintext ^ key;
               rk_reg    <= key;
               round_cnt <= 4'd1;
               fsm       <= ROUND;
            end
            ROUND: begin
               state_reg <= round_out;
               rk_reg    <= next_key;
               round_cnt <= round_cnt + 4'd1;
               if (last) begin
                  fsm        <= DONE;
                  ciphertext <= round_out;
                  out_valid  <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               fsm       <= IDLE;
               out_valid <= 1'b0;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words; only 4 is supported.
REQ-002 SHALL have parameter Nr, default 10, round count; only 10 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  plaintext and key are valid.
REQ-006 in_ready  output  1  block accepts a new job; high only in IDLE.
REQ-007 plaintext  input  128  input block; bits [127:120] are byte 0, column-major per FIPS-197.
REQ-008 key  input  32*Nk  cipher key, same byte order as plaintext.
REQ-009 out_valid  output  1  ciphertext is valid.
REQ-010 out_ready  input  1  downstream accepts ciphertext.
REQ-011 ciphertext  output  128  encrypted block, same byte order.
REQ-012 busy  output  1  high in ROUND or DONE.

Function
REQ-013 FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-014 Accept happens on the edge where in_valid && in_ready; plaintext and key are sampled only then.
REQ-015 On accept: state_reg <= plaintext ^ key (round 0), rk_reg <= key, round_cnt <= 1, FSM -> ROUND.
REQ-016 In ROUND, each edge SHALL perform, in order:
- derive next round key from rk_reg with the Rcon for round_cnt;
- SubBytes;
- ShiftRows;
- MixColumns, skipped when round_cnt == Nr;
- AddRoundKey with the derived key.
Then rk_reg <= derived key and round_cnt increments.
REQ-017 Rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36, with round_cnt 4 bits.
REQ-018 After the round_cnt == Nr edge: FSM -> DONE, ciphertext <= result, out_valid = 1. out_valid therefore rises exactly Nr edges after the accepting edge.
REQ-019 In DONE, ciphertext and out_valid SHALL hold stable while out_ready is low.
REQ-020 On the edge with out_valid && out_ready, FSM -> IDLE; in_ready is high in the following cycle. Minimum job spacing is Nr+2 cycles.
REQ-021 in_valid asserted while busy SHALL be ignored, with no state change.
REQ-022 Changes to plaintext or key after accept SHALL NOT affect the result in progress.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 ciphertext SHALL retain its last value after handshake until the next job completes.

Reset
REQ-025 Asserting rst SHALL immediately force: FSM IDLE, out_valid 0, ciphertext 0, state_reg 0, rk_reg 0, round_cnt 0.
REQ-026 in_ready SHALL read 1 and busy 0 during reset.
REQ-027 Reset mid-ROUND or in DONE SHALL abort the job; no out_valid follows for the aborted job.
REQ-028 The first accept is permitted on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package aes_pkg SHALL hold:
- S-box function;
- xtime function;
- Rcon table;
- FSM state typedef;
- constants for the 128-bit block width.
REQ-030 Single sub-module aes_key_step SHALL compute one AES-128 key-expansion round (128-bit key in, Rcon in, next 128-bit key out), purely combinational.
REQ-031 Round datapath SHALL be one combinational round per cycle, with no pipelining across jobs.

Verification
REQ-032 Appendix B vector: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
REQ-033 Appendix C.1 vector: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Back-pressure: hold out_ready low 20 cycles after out_valid -> ciphertext stable, in_ready low throughout; out_ready high -> IDLE, in_ready high the next cycle.
REQ-035 Busy-ignore: pulse in_valid with a different plaintext during ROUND -> first job's ciphertext is unchanged, and no second job starts.
REQ-036 Reset abort: assert rst at round 5, deassert, run the C.1 vector -> no spurious out_valid; correct C.1 result 10 edges after the new accept.
REQ-037 Back-to-back: in_valid held high with both vectors queued, out_ready tied high -> both results correct, accepts spaced 12 cycles apart.
